// File: rtl/fpalu_scheduler_if.sv
`timescale 1ns/1ps
// fpalu_scheduler_if
// Signal bundle between two requesters, the shared FPalu and the
// fpalu_scheduler that arbitrates between them.
//   req0_* / req1_* : valid/ready request channels (a, b, op)
//   rsp_*           : valid/ready response channel (id, data, flags)
//   alu_*           : operand/opcode/start towards the ALU, result and
//                     status flags back from it
// Modports:
//   slave  - the scheduler's view (takes requests, drives the ALU)
//   master - the environment's view (requesters, consumer, ALU)
interface fpalu_scheduler_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic [4:0]       rsp_flags;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic             alu_cin;
    logic             alu_start;
    logic [WIDTH-1:0] alu_out;
    logic             alu_busy;
    logic             alu_valid;
    logic             alu_ovf;
    logic             alu_unf;
    logic             alu_dbz;
    logic             alu_zbz;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        input  alu_out, alu_busy, alu_valid,
        input  alu_ovf, alu_unf, alu_dbz, alu_zbz,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_flags,
        output alu_a, alu_b, alu_op, alu_cin, alu_start
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        output alu_out, alu_busy, alu_valid,
        output alu_ovf, alu_unf, alu_dbz, alu_zbz,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_flags,
        input  alu_a, alu_b, alu_op, alu_cin, alu_start
    );
endinterface

// File: rtl/fpalu_scheduler.sv
`timescale 1ns/1ps
// fpalu_scheduler
// Round-robin scheduler sharing one FPalu between two requesters. One
// operation is in flight at a time; the result returns on a single
// response channel tagged with the requester id.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - fpalu_scheduler_if.slave (request, response and ALU signals)
// Parameters:
//   WIDTH    - operand/result width
//   COMB_LAT - settle cycles for opcodes 000/001/010/100 (1..15)
//   TIMEOUT  - divide watchdog limit in cycles
// Optional feature:
//   FPALU_SCHED_TIMEOUT_EN - when defined, a divide that sees no alu_valid
//   within TIMEOUT cycles is answered with err=1 and data=0.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for a request, granted port's ready asserted
// S_ISSUE   | operands held; pulse alu_start (divide) or load settle count
// S_WAIT_C  | combinational op settling, counter runs down to 0
// S_WAIT_MC | divide in progress, waiting for alu_valid
// S_RESP    | response presented until rsp_ready
module fpalu_scheduler #(
    parameter int WIDTH    = 32,
    parameter int COMB_LAT = 2,
    parameter int TIMEOUT  = 64
) (
    input logic             clk,
    input logic             rst_n,
    fpalu_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_C,
        S_WAIT_MC,
        S_RESP
    } state_t;

    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [4:0] FLG_ERR = 5'b10000;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [4:0]       flags_q, flags_d;
    logic [3:0]       cnt_q, cnt_d;

    logic grant0, grant1;
    logic op_illegal;
    logic wd_expired;
    logic unused_busy;

    // Divide completion is sequenced on alu_valid alone.
    assign unused_busy = bus.alu_busy;

    // The port other than last_q wins when both are valid.
    assign grant0     = bus.req0_valid & (last_q | ~bus.req1_valid);
    assign grant1     = bus.req1_valid & ~grant0;
    assign op_illegal = op_q[2] & (|op_q[1:0]);

`ifdef FPALU_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    assign wd_expired = (wd_q == '0);

    always_comb begin
        wd_d = wd_q;
        if (state_q == S_ISSUE) begin
            wd_d = WD_W'(TIMEOUT - 1);
        end else if (state_q == S_WAIT_MC && !wd_expired) begin
            wd_d = wd_q - WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign wd_expired = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (op_q == OP_DIV)  state_d = S_WAIT_MC;
                else if (op_illegal) state_d = S_RESP;
                else                 state_d = S_WAIT_C;
            end
            S_WAIT_C: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
            end
            S_WAIT_MC: begin
                if (bus.alu_valid || wd_expired) state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; readies are also forced low while reset is asserted so the
    // whole output set clears asynchronously.
    always_comb begin
        bus.req0_ready = rst_n & (state_q == S_IDLE) & grant0;
        bus.req1_ready = rst_n & (state_q == S_IDLE) & grant1;
        bus.rsp_valid  = (state_q == S_RESP);
        bus.alu_start  = (state_q == S_ISSUE) & (op_q == OP_DIV);
    end

    assign bus.alu_cin   = 1'b0;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_op    = op_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_flags = flags_q;

    // Holding, result and counter next values
    always_comb begin
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        data_d  = data_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant0) begin
                    a_d  = bus.req0_a;
                    b_d  = bus.req0_b;
                    op_d = bus.req0_op;
                    id_d = 1'b0;
                end else if (grant1) begin
                    a_d  = bus.req1_a;
                    b_d  = bus.req1_b;
                    op_d = bus.req1_op;
                    id_d = 1'b1;
                end
            end
            S_ISSUE: begin
                cnt_d = 4'(COMB_LAT - 1);
                if (op_illegal) begin
                    data_d  = '0;
                    flags_d = FLG_ERR;
                end
            end
            S_WAIT_C: begin
                if (cnt_q == 4'd0) begin
                    data_d  = bus.alu_out;
                    flags_d = {1'b0, bus.alu_ovf, bus.alu_unf, bus.alu_dbz, bus.alu_zbz};
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WAIT_MC: begin
                if (bus.alu_valid) begin
                    data_d  = bus.alu_out;
                    flags_d = {1'b0, bus.alu_ovf, bus.alu_unf, bus.alu_dbz, bus.alu_zbz};
                end else if (wd_expired) begin
                    data_d  = '0;
                    flags_d = FLG_ERR;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) last_d = id_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fpalu_scheduler.sv
`timescale 1ns/1ps
// tb_fpalu_scheduler
// Directed bench for fpalu_scheduler with an XOR ALU stub and a divide
// stub that answers a programmable number of cycles after alu_start.
module tb_fpalu_scheduler;

    localparam int WIDTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int cyc       = 0;
    int n_vec     = 0;
    int n_err     = 0;
    int div_delay = 10;
    bit div_en    = 1'b1;
    int div_cnt   = -1;
    int start_cnt = 0;
    int start_cyc = -1;

    fpalu_scheduler_if #(.WIDTH(WIDTH)) bus ();

    fpalu_scheduler #(
        .WIDTH    (WIDTH),
        .COMB_LAT (2),
        .TIMEOUT  (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.alu_out = bus.alu_a ^ bus.alu_b;

    // Divide stub and alu_start monitor, evaluated mid-cycle
    always @(negedge clk) begin
        bus.alu_valid = 1'b0;
        if (bus.alu_start) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
        if (!rst_n) begin
            div_cnt = -1;
        end else if (bus.alu_start) begin
            div_cnt = div_delay;
        end else if (div_cnt > 0) begin
            div_cnt = div_cnt - 1;
            if (div_cnt == 0 && div_en) bus.alu_valid = 1'b1;
        end
        bus.alu_busy = (div_cnt > 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic raise_req(input int p, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op);
        @(posedge clk); #1;
        if (p == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
    endtask

    task automatic drop_req(input int p);
        @(posedge clk); #1;
        if (p == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_hs(input int p, output int n);
        bit seen = 1'b0;
        n = -1;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if ((p == 0) ? bus.req0_ready : bus.req1_ready) begin
                seen = 1'b1;
                n    = cyc;
            end
        end
        check("hs_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_rsp(input int budget, output int m);
        bit seen = 1'b0;
        m = -1;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1'b1;
                m    = cyc;
            end
        end
        check("rsp_seen", 32'(seen), 32'd1);
    endtask

    task automatic do_req(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, output int n);
        raise_req(p, a, b, op);
        wait_hs(p, n);
        drop_req(p);
    endtask

    function automatic logic [31:0] cont_a(input int p, input int k);
        return 32'hA000_0000 + 32'(p) * 32'h0100_0000 + 32'(k);
    endfunction

    localparam logic [31:0] CONT_B = 32'h0000_5A5A;

    task automatic send_seq(input int p);
        logic [2:0] ops [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
        int n;
        for (int k = 0; k < 4; k++) begin
            raise_req(p, cont_a(p, k), CONT_B, ops[k]);
            wait_hs(p, n);
        end
        drop_req(p);
    endtask

    task automatic collect();
        int m;
        for (int j = 0; j < 8; j++) begin
            wait_rsp(200, m);
            check("cont_id", 32'(bus.rsp_id), 32'(j % 2));
            check("cont_data", bus.rsp_data, cont_a(j % 2, j / 2) ^ CONT_B);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "time limit");
    end

    initial begin
        int n, m, n2, m2, s0;
        bit late_rsp;

        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp_ready  = 1'b1;
        bus.alu_busy   = 1'b0;
        bus.alu_valid  = 1'b0;
        bus.alu_ovf    = 1'b0; bus.alu_unf = 1'b0; bus.alu_dbz = 1'b0; bus.alu_zbz = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
        check("rst_rsp_data",  bus.rsp_data,       32'd0);
        check("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        check("rst_alu_a",     bus.alu_a,          32'd0);
        check("rst_alu_op",    32'(bus.alu_op),    32'd0);
        check("rst_alu_start", 32'(bus.alu_start), 32'd0);
        check("rst_alu_cin",   32'(bus.alu_cin),   32'd0);

        // Contention: both ports valid continuously, grants alternate 0,1,...
        fork
            send_seq(0);
            send_seq(1);
            collect();
        join

        // Add on port 0 with rsp_ready held high
        do_req(0, 32'h4136_0000, 32'h40B2_0419, 3'b000, n);
        wait_rsp(50, m);
        check("add_lat",   32'(m - n),         32'd4);
        check("add_data",  bus.rsp_data,       32'h0184_0419);
        check("add_id",    32'(bus.rsp_id),    32'd0);
        check("add_flags", 32'(bus.rsp_flags), 32'd0);

        // Divide on port 1, stub answers 10 cycles after start with dbz
        bus.alu_dbz = 1'b1;
        s0 = start_cnt;
        do_req(1, 32'h3F80_0000, 32'h0000_0001, 3'b011, n);
        wait_rsp(100, m);
        check("div_start_cnt", 32'(start_cnt - s0), 32'd1);
        check("div_start_cyc", 32'(start_cyc),     32'(n + 1));
        check("div_lat",       32'(m - start_cyc), 32'd11);
        check("div_flags",     32'(bus.rsp_flags), 32'b00010);
        check("div_data",      bus.rsp_data,       32'h3F80_0001);
        check("div_id",        32'(bus.rsp_id),    32'd1);
        @(posedge clk); #1 bus.alu_dbz = 1'b0;

        // Backpressure: response held 5 cycles while port 1 waits
        bus.rsp_ready = 1'b0;
        do_req(0, 32'h1111_2222, 32'h0F0F_0F0F, 3'b001, n);
        wait_rsp(50, m);
        check("bp_data", bus.rsp_data, 32'h1E1E_2D2D);
        raise_req(1, 32'h5555_0000, 32'h0000_AAAA, 3'b100);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_data",  bus.rsp_data,       32'h1E1E_2D2D);
            check("bp_flags", 32'(bus.rsp_flags), 32'd0);
            check("bp_id",    32'(bus.rsp_id),    32'd0);
            check("bp_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        wait_hs(1, n2);
        check("bp_next_hs", 32'(n2 - m), 32'd6);
        drop_req(1);
        wait_rsp(50, m2);
        check("bp_next_lat",  32'(m2 - n2),      32'd4);
        check("bp_next_data", bus.rsp_data,      32'h5555_AAAA);
        check("bp_next_id",   32'(bus.rsp_id),   32'd1);

        // Illegal opcode: error response in N+2, ALU not started
        s0 = start_cnt;
        do_req(0, 32'h1234_5678, 32'h9ABC_DEF0, 3'b110, n);
        wait_rsp(50, m);
        check("ill_lat",   32'(m - n),          32'd2);
        check("ill_data",  bus.rsp_data,        32'd0);
        check("ill_flags", 32'(bus.rsp_flags),  32'b10000);
        check("ill_start", 32'(start_cnt - s0), 32'd0);

        // Reset three cycles after alu_start of a divide
        do_req(1, 32'h4049_0FDB, 32'h3F00_0000, 3'b011, n);
        while (cyc != n + 4) @(negedge clk);
        check("mid_alu_a", bus.alu_a, 32'h4049_0FDB);
        check("mid_id",    32'(bus.rsp_id), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("arst_rsp_id",    32'(bus.rsp_id),    32'd0);
        check("arst_rsp_data",  bus.rsp_data,       32'd0);
        check("arst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        check("arst_alu_a",     bus.alu_a,          32'd0);
        check("arst_alu_b",     bus.alu_b,          32'd0);
        check("arst_alu_op",    32'(bus.alu_op),    32'd0);
        check("arst_alu_start", 32'(bus.alu_start), 32'd0);
        check("arst_alu_cin",   32'(bus.alu_cin),   32'd0);
        check("arst_ready",     32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        late_rsp = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) late_rsp = 1'b1;
        end
        check("arst_discard", 32'(late_rsp), 32'd0);

        // After reset port 0 has priority again
        raise_req(0, 32'hC0DE_0000, 32'h0000_BEEF, 3'b010);
        bus.req1_valid = 1'b1; bus.req1_a = 32'h1; bus.req1_b = 32'h2; bus.req1_op = 3'b000;
        @(negedge clk);
        n = cyc;
        check("post_grant", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_rsp(50, m);
        check("post_lat",  32'(m - n),       32'd4);
        check("post_data", bus.rsp_data,     32'hC0DE_BEEF);
        check("post_id",   32'(bus.rsp_id),  32'd0);

`ifdef FPALU_SCHED_TIMEOUT_EN
        // Divide that never completes is answered by the watchdog
        div_en = 1'b0;
        do_req(0, 32'h7F00_0000, 32'h0000_0001, 3'b011, n);
        wait_rsp(200, m);
        check("to_lat",   32'(m - start_cyc), 32'd65);
        check("to_data",  bus.rsp_data,       32'd0);
        check("to_flags", 32'(bus.rsp_flags), 32'b10000);
        repeat (15) @(posedge clk);
        #1 div_en = 1'b1;
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpalu_scheduler.md
# fpalu_scheduler

Two-port round-robin scheduler that shares the single floating-point ALU (FPalu) between two requesters. It accepts operations on valid/ready request channels, drives the ALU operand and opcode ports, and sequences the ALU's `start`/`busy`/`valid` protocol for the multi-cycle divide. It also waits a fixed settle time for the combinational operations. Each result returns on a single valid/ready response channel tagged with the requester id.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width (IEEE-754 single precision).
- `COMB_LAT`, 2: settle cycles for ALU opcodes 000, 001, 010 and 100; legal range 1..15.
- `TIMEOUT`, 64: divide watchdog limit in cycles; used only with `FPALU_SCHED_TIMEOUT_EN`.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `req0_valid` / `req1_valid`  in  1: request present.
- `req0_ready` / `req1_ready`  out  1: request accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH: operands.
- `req0_op` / `req1_op`  in  3: ALU opcode.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: consumer accepts response.
- `rsp_id`  out  1: requester that issued the response.
- `rsp_data`  out  WIDTH: result.
- `rsp_flags`  out  5: {err, ovf, unf, dbz, zbz}.
- `alu_a`, `alu_b`  out  WIDTH: ALU operands.
- `alu_op`  out  3: ALU opcode.
- `alu_cin`  out  1: tied 0.
- `alu_start`  out  1: one-cycle divide start pulse.
- `alu_out`  in  WIDTH: ALU result.
- `alu_busy`, `alu_valid`  in  1: divide status from the ALU.
- `alu_ovf`, `alu_unf`, `alu_dbz`, `alu_zbz`  in  1: ALU exception flags.

## Operation
- The FSM has five states: IDLE, ISSUE, WAIT_C, WAIT_MC and RESP.
- **IDLE:**
  - The round-robin pointer `last` (reset value 1) selects the priority port; the port other than `last` has priority.
  - The granted port's ready is asserted combinationally only in IDLE and only for that port; both readies are 0 in every other state.
  - On handshake, capture a, b, op and id into holding registers and go to ISSUE.
- **Drive rules:** `alu_a`, `alu_b` and `alu_op` are driven from the holding registers at all times, so they stay stable for the whole operation.
- **ISSUE:** branch on the captured opcode.
  - Opcode 011: assert `alu_start` for exactly this cycle, then go to WAIT_MC.
  - Opcodes 000, 001, 010, 100: load the settle counter with COMB_LAT-1, then go to WAIT_C.
  - Opcodes 101–111: illegal. Skip the ALU, set err=1 and data=0, then go to RESP.
- **WAIT_C:** decrement the counter. When it is 0, capture `alu_out` and the four flags, then go to RESP.
- **WAIT_MC:** when `alu_valid`=1, capture `alu_out` and the flags, then go to RESP.
  - `alu_busy` is ignored for sequencing.
- **RESP:**
  - `rsp_valid`=1; data, flags and id are held stable until `rsp_ready`=1.
  - On that handshake, set `last` to the served id and go to IDLE.
- **Same-cycle response and request:** a new request cannot be accepted in the same cycle a response completes, because readies are 0 in RESP.
- **Arbitration:** with both requests valid continuously, grants alternate 0,1,0,1. A single active requester is granted back-to-back.
- **Reset:** asserting `rst_n` low at any time, including mid-operation, forces the following; an in-flight divide result is discarded.
  - State returns to IDLE and `last` to 1.
  - All outputs go to 0: readies, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_flags`, `alu_a`, `alu_b`, `alu_op`, `alu_start` and `alu_cin`.

## Timing
- Request handshake in cycle N puts the FSM in ISSUE in cycle N+1.
- Combinational op: `rsp_valid` rises in cycle N+2+COMB_LAT. With the default COMB_LAT=2 that is N+4.
- Divide: `alu_start` is high in cycle N+1. If `alu_valid` is first seen in cycle M, `rsp_valid` rises in M+1.
- Illegal op: `rsp_valid` rises in cycle N+2.
- Throughput: at most one operation in flight; the minimum spacing between request handshakes is COMB_LAT+3 cycles.

## Configuration
- Macro: `FPALU_SCHED_TIMEOUT_EN`.
- **Defined:** a watchdog counter runs in WAIT_MC.
  - After TIMEOUT cycles without `alu_valid`, go to RESP with err=1, data=0 and ovf/unf/dbz/zbz=0.
  - A late `alu_valid` arriving after that is ignored.
- **Undefined:** no counter is built, and WAIT_MC waits indefinitely for `alu_valid`.
- In both builds, err is still set for illegal opcodes.

## Test plan
All scenarios use an ALU stub whose combinational `alu_out` = `alu_a` ^ `alu_b`.
- **Add:** req0 sends a=0x41360000, b=0x40B20419, op=000 with `rsp_ready` held at 1.
  - Required: `rsp_valid` in cycle N+4, `rsp_data`=0x01840419, `rsp_id`=0, flags=0.
- **Contention:** both ports request continuously, 4 operations each.
  - Required: `rsp_id` order 0,1,0,1,0,1,0,1; no request dropped or duplicated.
- **Divide:** the stub asserts `alu_valid` 10 cycles after `alu_start`, with `alu_dbz`=1.
  - Required: one-cycle `alu_start` in N+1; response in the cycle after `alu_valid`; `rsp_flags`=5'b00010.
- **Backpressure and illegal op:** `rsp_ready` held 0 for 5 cycles; separately, op=110 is issued.
  - Required with backpressure: `rsp_data`, `rsp_flags` and `rsp_id` stay stable for all 5 cycles and both readies stay 0.
  - Required for op=110: response in N+2 with err=1, data=0, and no `alu_start` pulse.
- **Reset mid-divide:** assert `rst_n` low 3 cycles after `alu_start`.
  - Required: all outputs go to 0 immediately (asynchronously), then the next request is served normally.
- **Timeout (`FPALU_SCHED_TIMEOUT_EN` defined, TIMEOUT=64):** the stub never asserts `alu_valid`.
  - Required: err response 65 cycles after `alu_start`.
